// File: rtl/adder_submodule.sv
// Registered unsigned adder: captures two operands on enable and presents a
// zero-extended sum plus a valid flag one clock later.
module adder_submodule #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  number1,
  input  logic [IN_W-1:0]  number2,
  input  logic             enable,
  output logic [OUT_W-1:0] sum_result,
  output logic             sum_state
);

  typedef enum logic {IDLE, DONE} state_t;

  state_t           state;
  logic [1:0]       rst_sync;
  logic             run;
  logic [OUT_W-1:0] sum_next;

  // Reset asserts at once but releases only after two clean edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run      = rst_sync[1];
  assign sum_next = OUT_W'(number1) + OUT_W'(number2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sum_result <= '0;
      sum_state  <= 1'b0;
    end else if (run) begin
      case (state)
        IDLE: begin
          if (enable) begin
            sum_result <= sum_next;
            sum_state  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (enable) begin
            sum_result <= sum_next;
            sum_state  <= 1'b1;
          end else begin
            sum_state  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          sum_state <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_submodule.sv
// Directed self-checking bench for adder_submodule with hand-computed sums.
module tb_adder_submodule;

  logic        clk;
  logic        reset;
  logic [11:0] number1;
  logic [11:0] number2;
  logic        enable;
  logic [13:0] sum_result;
  logic        sum_state;

  int checks = 0;
  int errors = 0;

  adder_submodule #(.IN_W(12), .OUT_W(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .number1    (number1),
    .number2    (number2),
    .enable     (enable),
    .sum_result (sum_result),
    .sum_state  (sum_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic [11:0] a, input logic [11:0] b, input logic en);
    @(negedge clk);
    number1 = a;
    number2 = b;
    enable  = en;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [13:0] exp_sum, input logic exp_state);
    check_output({tag, "_sum"}, sum_result, exp_sum);
    check_output({tag, "_state"}, {13'd0, sum_state}, {13'd0, exp_state});
  endtask

  initial begin
    reset   = 1'b0;
    number1 = '0;
    number2 = '0;
    enable  = 1'b0;
    #2;
    check_both("reset_low", 14'd0, 1'b0);

    // Release with enable low: outputs stay cleared.
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(12'd0, 12'd0, 1'b0);
    check_both("post_rel1", 14'd0, 1'b0);
    apply_stimulus(12'd0, 12'd0, 1'b0);
    check_both("post_rel2", 14'd0, 1'b0);
    apply_stimulus(12'd0, 12'd0, 1'b0);
    check_both("post_rel3", 14'd0, 1'b0);

    apply_stimulus(12'd367, 12'd980, 1'b1);
    check_both("add_1347", 14'd1347, 1'b1);
    apply_stimulus(12'd367, 12'd980, 1'b0);
    check_both("drop_1347", 14'd1347, 1'b0);

    apply_stimulus(12'd300, 12'd157, 1'b1);
    check_both("add_457", 14'd457, 1'b1);
    apply_stimulus(12'd55, 12'd66, 1'b0);
    check_both("hold_457", 14'd457, 1'b0);
    apply_stimulus(12'd999, 12'd850, 1'b1);
    check_both("add_1849", 14'd1849, 1'b1);

    // Asynchronous reset between edges must clear the outputs without a clock.
    #2;
    reset = 1'b0;
    #1;
    check_both("async_rst", 14'd0, 1'b0);
    apply_stimulus(12'd123, 12'd456, 1'b0);
    check_both("rst_hold", 14'd0, 1'b0);

    // Enable raised in the same cycle reset releases is ignored for two edges.
    @(negedge clk);
    reset   = 1'b1;
    number1 = 12'd5;
    number2 = 12'd6;
    enable  = 1'b1;
    @(posedge clk);
    #1;
    check_both("sync_e1", 14'd0, 1'b0);
    @(posedge clk);
    #1;
    check_both("sync_e2", 14'd0, 1'b0);
    @(posedge clk);
    #1;
    check_both("sync_e3", 14'd11, 1'b1);

    apply_stimulus(12'd1, 12'd2, 1'b1);
    check_both("b2b_3", 14'd3, 1'b1);
    apply_stimulus(12'd10, 12'd20, 1'b1);
    check_both("b2b_30", 14'd30, 1'b1);
    apply_stimulus(12'd100, 12'd200, 1'b1);
    check_both("b2b_300", 14'd300, 1'b1);

    apply_stimulus(12'd4095, 12'd4095, 1'b1);
    check_both("max_8190", 14'd8190, 1'b1);
    check_output("max_bit13", {13'd0, sum_result[13]}, 14'd0);
    apply_stimulus(12'd4095, 12'd4095, 1'b0);
    check_both("drop_8190", 14'd8190, 1'b0);
    apply_stimulus(12'd7, 12'd7, 1'b0);
    check_both("idle_opchg", 14'd8190, 1'b0);

    // Fresh add from IDLE after the hold period.
    apply_stimulus(12'd2048, 12'd1, 1'b1);
    check_both("add_2049", 14'd2049, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
